// File: rtl/seg7_scan_pkg.sv
// Shared types, constants and the hex font
// for the multiplexed 7-segment display stage.
package seg7_scan_pkg;

  typedef logic [7:0] seg_t;

  localparam seg_t       SEG_OFF = 8'hFF;
  localparam logic [3:0] SEL_OFF = 4'hF;

  typedef enum logic [1:0] {
    SOLID     = 2'd0,
    BLINK_ON  = 2'd1,
    BLINK_OFF = 2'd2
  } blink_state_e;

  // Active-low font, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(
    input logic [3:0] nib
  );
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Nibble to segment pattern with blanking
// and decimal-point control, all active-low.
module seg7_decode
  import seg7_scan_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  input  logic       dp_on,
  output seg_t       seg
);

  // Blanked digits go fully dark, DP included.
  always_comb begin
    seg = {~dp_on, hex_to_seg(nibble)};
    if (blank) seg = SEG_OFF;
  end

endmodule

// File: rtl/seg7_scan.sv
// Scans a 16-bit value onto a 4-digit muxed
// 7-segment display with frame-aligned updates.
module seg7_scan
  import seg7_scan_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic [15:0] disp_value,
  input  logic        disp_we,
  input  logic        blank_lz,
  input  logic        do_halt,
  output logic [7:0]  SEG,
  output logic [3:0]  SEG_SEL
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int FW = $clog2(BLINK_FRAMES) + 1;

  localparam logic [PW-1:0] PRESC_MAX =
    PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRAME_MAX =
    FW'(BLINK_FRAMES - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    digit_q, digit_d;
  logic [15:0]   shown_q, shown_d;
  logic [15:0]   pending_q, pending_d;
  logic          pend_v_q, pend_v_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  blink_state_e  state_q, state_d;
  seg_t          seg_q, seg_d;
  logic [3:0]    sel_q, sel_d;

  logic          wrap;
  logic          boundary;
  logic          blink_off_d;
  logic [3:0]    nib;
  logic          lz;
  logic          dp_on;
  seg_t          dec_seg;
  logic [3:0]    sel_hot;

  assign wrap     = (presc_q == PRESC_MAX);
  assign boundary = wrap && (digit_q == 2'd3);

  // Slot prescaler and digit counter.
  always_comb begin
    presc_d = presc_q + 1'b1;
    digit_d = digit_q;
    if (wrap) begin
      presc_d = '0;
      digit_d = digit_q + 2'd1;
    end
  end

  // Pending/shown transfer; a write in the
  // boundary cycle is kept for the next frame.
  always_comb begin
    shown_d   = shown_q;
    pending_d = pending_q;
    pend_v_d  = pend_v_q;
    if (boundary && pend_v_q) begin
      shown_d  = pending_q;
      pend_v_d = 1'b0;
    end
    if (disp_we) begin
      pending_d = disp_value;
      pend_v_d  = 1'b1;
    end
  end

  // Blink FSM: halves counted in whole frames.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    unique case (state_q)
      SOLID: begin
        frame_cnt_d = '0;
        if (do_halt) state_d = BLINK_ON;
      end
      BLINK_ON, BLINK_OFF: begin
        if (!do_halt) begin
          state_d     = SOLID;
          frame_cnt_d = '0;
        end else if (boundary) begin
          if (frame_cnt_q == FRAME_MAX) begin
            frame_cnt_d = '0;
            state_d = (state_q == BLINK_ON) ?
                      BLINK_OFF : BLINK_ON;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d     = SOLID;
        frame_cnt_d = '0;
      end
    endcase
  end

  assign blink_off_d = (state_d == BLINK_OFF);

  // Digit mux and leading-zero detection.
  always_comb begin
    nib = shown_q[3:0];
    lz  = 1'b0;
    unique case (digit_q)
      2'd0: begin
        nib = shown_q[3:0];
        lz  = 1'b0;
      end
      2'd1: begin
        nib = shown_q[7:4];
        lz  = (shown_q[15:4] == 12'd0);
      end
      2'd2: begin
        nib = shown_q[11:8];
        lz  = (shown_q[15:8] == 8'd0);
      end
      2'd3: begin
        nib = shown_q[15:12];
        lz  = (shown_q[15:12] == 4'd0);
      end
      default: begin
        nib = shown_q[3:0];
        lz  = 1'b0;
      end
    endcase
  end

  assign dp_on   = do_halt && (digit_q == 2'd0);
  assign sel_hot = ~(4'b0001 << digit_q);

  seg7_decode u_dec (
    .nibble (nib),
    .blank  (blank_lz && lz),
    .dp_on  (dp_on),
    .seg    (dec_seg)
  );

  // Output staging: dark for the dead-time
  // cycle after a wrap, selects off while blinked.
  always_comb begin
    seg_d = dec_seg;
    sel_d = sel_hot;
    if (wrap) begin
      seg_d = SEG_OFF;
      sel_d = SEL_OFF;
    end else if (blink_off_d) begin
      sel_d = SEL_OFF;
    end
  end

  // All state and the output pins.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      presc_q     <= '0;
      digit_q     <= '0;
      shown_q     <= '0;
      pending_q   <= '0;
      pend_v_q    <= 1'b0;
      frame_cnt_q <= '0;
      state_q     <= SOLID;
      seg_q       <= SEG_OFF;
      sel_q       <= SEL_OFF;
    end else begin
      presc_q     <= presc_d;
      digit_q     <= digit_d;
      shown_q     <= shown_d;
      pending_q   <= pending_d;
      pend_v_q    <= pend_v_d;
      frame_cnt_q <= frame_cnt_d;
      state_q     <= state_d;
      seg_q       <= seg_d;
      sel_q       <= sel_d;
    end
  end

  assign SEG     = seg_q;
  assign SEG_SEL = sel_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan with
// SCAN_DIV=4 and BLINK_FRAMES=2.
module tb_seg7_scan;

  logic        CLK;
  logic        rst;
  logic [15:0] disp_value;
  logic        disp_we;
  logic        blank_lz;
  logic        do_halt;
  logic [7:0]  SEG;
  logic [3:0]  SEG_SEL;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc;

  typedef struct {
    int         cyc;
    logic [7:0] seg;
    logic [3:0] sel;
  } exp_t;

  exp_t sb[$];

  seg7_scan #(
    .SCAN_DIV     (4),
    .BLINK_FRAMES (2)
  ) dut (
    .CLK        (CLK),
    .rst        (rst),
    .disp_value (disp_value),
    .disp_we    (disp_we),
    .blank_lz   (blank_lz),
    .do_halt    (do_halt),
    .SEG        (SEG),
    .SEG_SEL    (SEG_SEL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK or negedge rst)
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;

  task automatic chk(
    input string      name,
    input int         c,
    input logic [7:0] seg_a,
    input logic [7:0] seg_e,
    input logic [3:0] sel_a,
    input logic [3:0] sel_e
  );
    n_chk++;
    if (seg_a === seg_e && sel_a === sel_e)
      n_pass++;
    else
      $display("FAIL %s cyc=%0d got SEG=%h SEL=%h want SEG=%h SEL=%h",
               name, c, seg_a, sel_a, seg_e, sel_e);
  endtask

  // Monitor: compare every sample that has
  // an expectation queued for its cycle.
  always @(negedge CLK) begin : mon
    exp_t e;
    if (rst) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        if (e.cyc < cyc) begin
          n_chk++;
          $display("FAIL missed cyc=%0d now=%0d",
                   e.cyc, cyc);
        end else begin
          chk("scan", cyc, SEG, e.seg, SEG_SEL, e.sel);
        end
      end
    end
  end

  task automatic exp_cyc(
    input int c, input logic [7:0] s, input logic [3:0] l
  );
    exp_t e;
    e.cyc = c;
    e.seg = s;
    e.sel = l;
    sb.push_back(e);
  endtask

  task automatic exp_frame(
    input int f,
    input logic [7:0] s0, input logic [7:0] s1,
    input logic [7:0] s2, input logic [7:0] s3,
    input bit on
  );
    logic [7:0] s [4];
    logic [3:0] one;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    for (int d = 0; d < 4; d++) begin
      one = 4'b0001 << d;
      exp_cyc(16*f + 4*d, 8'hFF, 4'hF);
      for (int j = 1; j < 4; j++)
        exp_cyc(16*f + 4*d + j, s[d], on ? ~one : 4'hF);
    end
  endtask

  task automatic at(input int k);
    while (cyc < k) @(negedge CLK);
  endtask

  task automatic we_at(input int e, input logic [15:0] v);
    at(e - 1);
    disp_value = v;
    disp_we    = 1'b1;
    at(e);
    disp_we    = 1'b0;
  endtask

  initial begin
    rst        = 1'b0;
    disp_value = '0;
    disp_we    = 1'b0;
    blank_lz   = 1'b0;
    do_halt    = 1'b0;
    #12;
    chk("reset_state", 0, SEG, 8'hFF, SEG_SEL, 4'hF);

    // blank_lz=0, zero value
    exp_frame(0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 1);
    exp_frame(1, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 1);
    // 0270 with leading-zero blanking
    exp_frame(2, 8'hC0, 8'hF8, 8'hA4, 8'hFF, 1);
    exp_frame(3, 8'hC0, 8'hF8, 8'hA4, 8'hFF, 1);
    // 1111 overwritten by 2222
    exp_frame(4, 8'hA4, 8'hA4, 8'hA4, 8'hA4, 1);
    // 1234 transferred on the boundary write
    exp_frame(5, 8'h99, 8'hB0, 8'hA4, 8'hF9, 1);
    exp_frame(6, 8'hA1, 8'hC6, 8'h83, 8'h88, 1);
    // halted on 624: on, on, off, off
    exp_frame(7, 8'h40, 8'hF8, 8'hA4, 8'hFF, 1);
    exp_frame(8, 8'h40, 8'hF8, 8'hA4, 8'hFF, 1);
    exp_frame(9, 8'h40, 8'hF8, 8'hA4, 8'hFF, 0);
    // halt dropped, sampled on edge 166
    exp_cyc(160, 8'hFF, 4'hF);
    for (int j = 161; j < 164; j++)
      exp_cyc(j, 8'h40, 4'hF);
    exp_cyc(164, 8'hFF, 4'hF);
    exp_cyc(165, 8'hF8, 4'hF);
    exp_cyc(166, 8'hF8, 4'hD);
    exp_cyc(167, 8'hF8, 4'hD);
    exp_cyc(168, 8'hFF, 4'hF);
    for (int j = 169; j < 172; j++)
      exp_cyc(j, 8'hA4, 4'hB);
    exp_cyc(172, 8'hFF, 4'hF);
    for (int j = 173; j < 176; j++)
      exp_cyc(j, 8'hFF, 4'h7);
    exp_frame(11, 8'hC0, 8'hF8, 8'hA4, 8'hFF, 1);

    @(posedge CLK);
    #1 rst = 1'b1;

    we_at(22, 16'h0270);
    at(31);
    blank_lz = 1'b1;
    we_at(50, 16'h1111);
    we_at(54, 16'h2222);
    we_at(70, 16'h1234);
    we_at(80, 16'hABCD);
    we_at(100, 16'h0270);
    at(111);
    do_halt = 1'b1;
    at(165);
    do_halt = 1'b0;

    at(198);
    chk("pre_reset", cyc, SEG, 8'hF8, SEG_SEL, 4'hD);
    #2 rst = 1'b0;
    #1;
    chk("async_reset", cyc, SEG, 8'hFF, SEG_SEL, 4'hF);
    if (sb.size() != 0) begin
      n_chk++;
      $display("FAIL queue_left entries=%0d", sb.size());
      sb.delete();
    end
    repeat (3) @(negedge CLK);
    chk("held_reset", cyc, SEG, 8'hFF, SEG_SEL, 4'hF);

    // Restart: shown cleared, digit 0 first
    exp_frame(0, 8'hC0, 8'hFF, 8'hFF, 8'hFF, 1);
    @(posedge CLK);
    #1 rst = 1'b1;

    for (int i = 0; i < 40 && sb.size() > 0; i++)
      @(negedge CLK);
    if (sb.size() != 0) begin
      n_chk++;
      $display("FAIL drain_timeout entries=%0d", sb.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
